// File: rtl/spi_mode3_target_if.sv
// SPI pins plus the fabric-side TX/RX valid/ready channels of the mode-3 SPI target.
// slave = the target itself, master = whatever drives the SPI pins and fabric channels.
interface spi_mode3_target_if #(
    parameter int FRAME_SIZE = 8
);
    logic                  SPISCLK;
    logic                  SPISS;
    logic                  SPISDI;
    logic                  SPISDO;
    logic                  SPIOEN;
    logic [FRAME_SIZE-1:0] TX_DATA;
    logic                  TX_VALID;
    logic                  TX_READY;
    logic [FRAME_SIZE-1:0] RX_DATA;
    logic                  RX_VALID;
    logic                  RX_READY;
    logic                  RX_OVERRUN;
    logic                  TX_UNDERRUN;
    logic                  BUSY;
    logic                  state_dbg;

    modport slave (
        input  SPISCLK, SPISS, SPISDI, TX_DATA, TX_VALID, RX_READY,
        output SPISDO, SPIOEN, TX_READY, RX_DATA, RX_VALID,
               RX_OVERRUN, TX_UNDERRUN, BUSY, state_dbg
    );

    modport master (
        output SPISCLK, SPISS, SPISDI, TX_DATA, TX_VALID, RX_READY,
        input  SPISDO, SPIOEN, TX_READY, RX_DATA, RX_VALID,
               RX_OVERRUN, TX_UNDERRUN, BUSY, state_dbg
    );
endinterface

// File: rtl/spi_mode3_target.sv
// Mode-3 (CPOL=1, CPHA=1) MSB-first SPI target, oversampled in the PCLK domain,
// with one valid/ready holding register per direction.
module spi_mode3_target #(
    parameter int                    FRAME_SIZE  = 8,
    parameter logic [FRAME_SIZE-1:0] TX_IDLE     = {FRAME_SIZE{1'b1}},
    parameter int                    SYNC_STAGES = 2
) (
    input  logic               PCLK,
    input  logic               PRESET,
    spi_mode3_target_if.slave  bus
);
    // Handshakes: a transfer occurs on a PCLK rising edge where valid and ready are
    // both 1; valid holds its data until then and never depends on ready.
    localparam int CW = $clog2(FRAME_SIZE);
    localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_SIZE - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t                state;
    logic [CW-1:0]         bitcnt;
    logic [FRAME_SIZE-1:0] tx_shreg;
    logic [FRAME_SIZE-1:0] rx_shreg;
    logic [FRAME_SIZE-1:0] tx_hold;
    logic                  tx_ready;
    logic [FRAME_SIZE-1:0] rx_data;
    logic                  rx_valid;
    logic                  sdo;
    logic                  oen;
    logic                  busy;
    logic                  rx_overrun;
    logic                  tx_underrun;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic [SYNC_STAGES-1:0] ss_vld;
    logic                   sclk_d;
    logic                   ss_d;
    logic                   ss_armed;

    logic sclk_s, ss_s, sdi_s;
    logic sclk_fall, sclk_rise, ss_fall, ss_rise;
    logic frame_done, rx_store, load_frame;
    logic [FRAME_SIZE-1:0] rx_frame;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign sdi_s  = sdi_sync[SYNC_STAGES-1];

    // ss_armed needs a genuinely sampled high SS, so an SS held low across reset never starts a frame.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            sclk_sync <= '1;
            ss_sync   <= '1;
            sdi_sync  <= '0;
            ss_vld    <= '0;
            sclk_d    <= 1'b1;
            ss_d      <= 1'b1;
            ss_armed  <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.SPISCLK};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.SPISS};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], bus.SPISDI};
            ss_vld    <= {ss_vld[SYNC_STAGES-2:0], 1'b1};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
            ss_armed  <= ss_armed | (ss_vld[SYNC_STAGES-1] & ss_s);
        end
    end

    always_comb begin
        sclk_fall  = sclk_d & ~sclk_s;
        sclk_rise  = ~sclk_d & sclk_s;
        ss_fall    = ss_armed & ss_d & ~ss_s;
        ss_rise    = ~ss_d & ss_s;
        frame_done = (state == SHIFT) && sclk_rise && (bitcnt == LAST_BIT);
        rx_frame   = {rx_shreg[FRAME_SIZE-2:0], sdi_s};
        rx_store   = frame_done && (!rx_valid || bus.RX_READY);
        load_frame = ((state == IDLE) && ss_fall) || (frame_done && !ss_rise);
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state       <= IDLE;
            bitcnt      <= '0;
            tx_shreg    <= '0;
            rx_shreg    <= '0;
            tx_hold     <= '0;
            tx_ready    <= 1'b1;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            sdo         <= 1'b1;
            oen         <= 1'b0;
            busy        <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state <= SHIFT;
                        oen   <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (ss_rise) begin
                        state <= IDLE;
                        oen   <= 1'b0;
                        sdo   <= 1'b1;
                        busy  <= 1'b0;
                    end else if (sclk_fall) begin
                        sdo      <= tx_shreg[FRAME_SIZE-1];
                        tx_shreg <= tx_shreg << 1;
                    end else if (sclk_rise) begin
                        rx_shreg <= rx_frame;
                        bitcnt   <= bitcnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            // Fabric accept and frame load never coincide: one needs the register empty, the other full.
            if (tx_ready && bus.TX_VALID) begin
                tx_hold  <= bus.TX_DATA;
                tx_ready <= 1'b0;
            end

            if (load_frame) begin
                bitcnt <= '0;
                if (!tx_ready) begin
                    tx_shreg <= tx_hold;
                    tx_ready <= 1'b1;
                end else begin
                    tx_shreg    <= TX_IDLE;
                    tx_underrun <= 1'b1;
                end
            end

            if (rx_store) begin
                rx_data  <= rx_frame;
                rx_valid <= 1'b1;
            end else begin
                if (frame_done) rx_overrun <= 1'b1;
                if (rx_valid && bus.RX_READY) rx_valid <= 1'b0;
            end
        end
    end

    assign bus.SPISDO      = sdo;
    assign bus.SPIOEN      = oen;
    assign bus.TX_READY    = tx_ready;
    assign bus.RX_DATA     = rx_data;
    assign bus.RX_VALID    = rx_valid;
    assign bus.RX_OVERRUN  = rx_overrun;
    assign bus.TX_UNDERRUN = tx_underrun;
    assign bus.BUSY        = busy;
    assign bus.state_dbg   = state;
endmodule

// File: tb/tb_spi_mode3_target.sv
// Bench for spi_mode3_target: table of single frames plus hand-written corner sequences;
// received frames are checked against an expected queue as the DUT hands them over.
module tb_spi_mode3_target;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_mode3_target_if #(.FRAME_SIZE(8)) bus ();

  spi_mode3_target #(
    .FRAME_SIZE (8),
    .TX_IDLE    (8'hFF),
    .SYNC_STAGES(2)
  ) dut (
    .PCLK  (clk),
    .PRESET(rst),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int n_under = 0;
  int n_over = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;
  logic [7:0] m1, m2, mm;

  typedef struct {
    logic [7:0] mosi;
    logic [7:0] tx;
    bit         tx_en;
    logic [7:0] exp_miso;
    int         exp_under;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard side: pulse counters and RX handshake checker.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.TX_UNDERRUN) n_under++;
      if (bus.RX_OVERRUN) n_over++;
      if (bus.RX_VALID && bus.RX_READY) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rx_unexpected: got %0h, expected no frame", bus.RX_DATA);
        end else begin
          exp_v = exp_q.pop_front();
          check("rx_data", {24'h0, bus.RX_DATA}, {24'h0, exp_v});
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_tx(input logic [7:0] d);
    bit got = 0;
    bus.TX_DATA  = d;
    bus.TX_VALID = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      if (bus.TX_READY) got = 1;
      @(negedge clk);
    end
    bus.TX_VALID = 1'b0;
    check("tx_accept", {31'h0, got}, 32'h1);
  endtask

  // Master drives SDI on SCLK fall, samples SDO on SCLK rise; optional SS rise with the last rise.
  task automatic spi_frame(input logic [7:0] mosi, output logic [7:0] miso,
                           input int nbits, input bit last_ss);
    miso = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.SPISCLK = 1'b0;
      bus.SPISDI  = mosi[7-i];
      wait_clk(HALF);
      bus.SPISCLK = 1'b1;
      miso[7-i]   = bus.SPISDO;
      if (last_ss && i == nbits - 1) bus.SPISS = 1'b1;
      wait_clk(HALF);
    end
  endtask

  task automatic xfer(input logic [7:0] mosi, output logic [7:0] miso);
    bus.SPISS = 1'b0;
    wait_clk(HALF);
    spi_frame(mosi, miso, 8, 1);
    wait_clk(6);
  endtask

  task automatic run_frame(input logic [7:0] mosi, input logic [7:0] tx, input bit tx_en,
                           input logic [7:0] exp_miso, input int exp_under);
    int u0;
    logic [7:0] m;
    u0 = n_under;
    if (tx_en) send_tx(tx);
    exp_q.push_back(mosi);
    bus.SPISS = 1'b0;
    wait_clk(HALF);
    check("busy_in_frame", {31'h0, bus.BUSY}, 32'h1);
    check("oen_in_frame", {31'h0, bus.SPIOEN}, 32'h1);
    check("tx_ready_after_load", {31'h0, bus.TX_READY}, 32'h1);
    spi_frame(mosi, m, 8, 1);
    wait_clk(6);
    check("miso", {24'h0, m}, {24'h0, exp_miso});
    check("underrun_pulses", n_under - u0, exp_under);
    check("oen_idle", {31'h0, bus.SPIOEN}, 32'h0);
    check("sdo_idle", {31'h0, bus.SPISDO}, 32'h1);
    check("busy_idle", {31'h0, bus.BUSY}, 32'h0);
    wait_clk(4);
  endtask

  initial begin
    int u0, o0;
    logic [7:0] rm, rt;

    vecs[0] = '{8'hA5, 8'h3C, 1'b1, 8'h3C, 0};
    vecs[1] = '{8'h55, 8'h00, 1'b0, 8'hFF, 1};
    vecs[2] = '{8'hC3, 8'h96, 1'b1, 8'h96, 0};
    vecs[3] = '{8'h7E, 8'h81, 1'b1, 8'h81, 0};

    rst          = 1'b1;
    bus.SPISCLK  = 1'b1;
    bus.SPISS    = 1'b1;
    bus.SPISDI   = 1'b0;
    bus.TX_DATA  = 8'h00;
    bus.TX_VALID = 1'b0;
    bus.RX_READY = 1'b1;
    wait_clk(3);
    check("rst_sdo", {31'h0, bus.SPISDO}, 32'h1);
    check("rst_oen", {31'h0, bus.SPIOEN}, 32'h0);
    check("rst_tx_ready", {31'h0, bus.TX_READY}, 32'h1);
    check("rst_rx_valid", {31'h0, bus.RX_VALID}, 32'h0);
    check("rst_rx_data", {24'h0, bus.RX_DATA}, 32'h0);
    check("rst_busy", {31'h0, bus.BUSY}, 32'h0);
    rst = 1'b0;
    wait_clk(6);

    for (int v = 0; v < 4; v++)
      run_frame(vecs[v].mosi, vecs[v].tx, vecs[v].tx_en, vecs[v].exp_miso, vecs[v].exp_under);

    for (int r = 0; r < 4; r++) begin
      rm = 8'($urandom_range(0, 255));
      rt = 8'($urandom_range(0, 255));
      run_frame(rm, rt, 1'b1, rt, 0);
    end

    // Back-to-back frames, second TX word queued while the first frame shifts.
    u0 = n_under;
    o0 = n_over;
    send_tx(8'h01);
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h42);
    bus.SPISS = 1'b0;
    wait_clk(HALF);
    fork
      begin
        spi_frame(8'h81, m1, 8, 0);
        spi_frame(8'h42, m2, 8, 1);
      end
      begin
        wait_clk(20);
        send_tx(8'h02);
      end
    join
    wait_clk(6);
    check("b2b_miso1", {24'h0, m1}, 32'h01);
    check("b2b_miso2", {24'h0, m2}, 32'h02);
    check("b2b_underrun", n_under - u0, 0);
    check("b2b_overrun", n_over - o0, 0);
    wait_clk(4);

    // Overrun: consumer stalled across two frames.
    bus.RX_READY = 1'b0;
    o0 = n_over;
    xfer(8'h11, mm);
    check("ovr_first_none", n_over - o0, 0);
    wait_clk(4);
    xfer(8'h22, mm);
    check("ovr_rx_valid", {31'h0, bus.RX_VALID}, 32'h1);
    check("ovr_rx_data_kept", {24'h0, bus.RX_DATA}, 32'h11);
    check("ovr_pulse", n_over - o0, 1);
    exp_q.push_back(8'h11);
    bus.RX_READY = 1'b1;
    wait_clk(3);
    check("ovr_rx_drained", {31'h0, bus.RX_VALID}, 32'h0);
    wait_clk(4);

    // Abort after five SCLK rises, then a clean frame.
    bus.SPISS = 1'b0;
    wait_clk(HALF);
    spi_frame(8'hF0, mm, 5, 0);
    bus.SPISS = 1'b1;
    wait_clk(6);
    check("abort_rx_valid", {31'h0, bus.RX_VALID}, 32'h0);
    check("abort_oen", {31'h0, bus.SPIOEN}, 32'h0);
    check("abort_sdo", {31'h0, bus.SPISDO}, 32'h1);
    check("abort_busy", {31'h0, bus.BUSY}, 32'h0);
    wait_clk(4);
    exp_q.push_back(8'hC3);
    xfer(8'hC3, mm);
    check("abort_next_miso", {24'h0, mm}, 32'hFF);
    wait_clk(4);

    // Reset mid-frame with the TX holding register full.
    send_tx(8'h5A);
    bus.SPISS = 1'b0;
    wait_clk(HALF);
    send_tx(8'hA0);
    spi_frame(8'h12, mm, 3, 0);
    wait_clk(3);
    rst = 1'b1;
    wait_clk(1);
    check("mid_rst_sdo", {31'h0, bus.SPISDO}, 32'h1);
    check("mid_rst_oen", {31'h0, bus.SPIOEN}, 32'h0);
    check("mid_rst_tx_ready", {31'h0, bus.TX_READY}, 32'h1);
    check("mid_rst_rx_valid", {31'h0, bus.RX_VALID}, 32'h0);
    check("mid_rst_rx_data", {24'h0, bus.RX_DATA}, 32'h0);
    check("mid_rst_busy", {31'h0, bus.BUSY}, 32'h0);
    rst = 1'b0;
    wait_clk(20);
    check("no_frame_without_fresh_fall", {31'h0, bus.BUSY}, 32'h0);
    bus.SPISS = 1'b1;
    wait_clk(10);
    send_tx(8'h69);
    exp_q.push_back(8'h3C);
    xfer(8'h3C, mm);
    check("post_rst_miso", {24'h0, mm}, 32'h69);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) wait_clk(1);
    check("rx_queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
